midi_transmitter: RTL and testbench
===================================

// Module: midi_transmitter
// PURPOSE
//  Serial MIDI (UART 8N1, 31.25 kbaud) transmitter, the transmit-side counterpart of the MIDI input path.
//  Accepts bytes over a valid/ready handshake into a small FIFO and serialises them onto midi_tx.
//  Used for MIDI thru/echo and for sending controller/status messages to external gear.
//  Runs entirely in the SYSTEM_CLOCK (50 MHz) domain.
// PARAMETERS
//  CLOCK_FREQ  CONFIG::SYSTEM_CLOCK   input clock frequency, Hz
//  BAUD_RATE   CONFIG::MIDI_BAUD_RATE (31250)  serial bit rate, bits/s
//  FIFO_DEPTH  4                      bytes buffered ahead of the shifter; power of 2, >=2
// PORTS
//  clock      in   1                      system clock; all logic on its rising edge
//  reset_l    in   1                      asynchronous, active-low reset
//  tx_data    in   CONFIG::BYTE_WIDTH (8) byte to send
//  tx_valid   in   1                      tx_data valid this cycle
//  tx_ready   out  1                      FIFO can accept; transfer when tx_valid && tx_ready
//  midi_tx    out  1                      serial line; idle high
//  busy       out  1                      frame in progress or FIFO non-empty
//  fifo_count out  $clog2(FIFO_DEPTH)+1   bytes currently in FIFO (excludes the byte being shifted)
// BEHAVIOUR
//  Reset (async assert, sync release): midi_tx=1, tx_ready=1, busy=0, fifo_count=0; FIFO emptied, FSM=IDLE.
//  BIT_PERIOD = CLOCK_FREQ/BAUD_RATE (integer; 1600 at defaults). Elaboration fails if BIT_PERIOD<2.
//  Bit counter: $clog2(BIT_PERIOD) bits, counts 0..BIT_PERIOD-1, wraps to 0.
//  Frame: start bit 0, data bits LSB first, stop bit 1; each bit held exactly BIT_PERIOD cycles;
//   10*BIT_PERIOD cycles per frame (16000 at defaults).
//  tx_ready = (fifo_count != FIFO_DEPTH); derived from registered count only, never from tx_valid or pop.
//  Push when tx_valid && tx_ready; tx_data ignored otherwise.
//  FSM states:
//   IDLE  - midi_tx=1. If FIFO non-empty: pop head into shift reg, go START.
//   START - midi_tx=0 for BIT_PERIOD cycles, then go DATA with bit index 0.
//   DATA  - midi_tx=shift[idx] for BIT_PERIOD cycles; idx 0..7; after idx 7 go STOP.
//   STOP  - midi_tx=1 for BIT_PERIOD cycles. At end: if FIFO non-empty, pop and go START directly
//           (no idle cycle between frames); else go IDLE.
//  Latency: byte pushed at edge E into an empty FIFO with FSM in IDLE -> popped at edge E+1,
//   midi_tx falls low at edge E+1 (registered output).
//  Simultaneous push and pop in one cycle: count unchanged, both take effect; pushed byte lands behind
//   existing entries. Push into an empty FIFO on the pop cycle is not popped that cycle.
//  Full: tx_ready=0 until a pop; a pop while full raises tx_ready on the following cycle.
//  Pointers are log2(FIFO_DEPTH) bits and wrap naturally; count arithmetic is exact, no overflow
//   possible under the handshake.
//  busy = (state != IDLE) || (fifo_count != 0).
//  Reset mid-frame: line driven high immediately on reset_l assertion; partial frame and FIFO
//   contents discarded; no stop bit completed.
//  midi_tx is driven from a flop (glitch-free).
// STRUCTURE
//  CONFIG package additions: MIDI_BAUD_RATE=31250; typedef logic [BYTE_WIDTH-1:0] byte_t.
//  Sub-module byte_fifo (byte_t entries, DEPTH param, push/pop/count, async active-low reset),
//   reusable by the receive path; FSM, bit timer and shifter stay in midi_transmitter.
// TESTING
//  1 Reset: hold reset_l=0 5 cycles -> midi_tx=1, tx_ready=1, busy=0, fifo_count=0.
//  2 Single byte 0x90 at edge E -> midi_tx=0 from E+1 for 1600 cycles, then bits 0,0,0,0,1,0,0,1
//    each 1600 cycles, stop high 1600; busy drops at E+1+16000.
//  3 Push 0x90,0x3C,0x7F on consecutive cycles -> three contiguous frames, 48000 cycles total,
//    no extra idle cycle; sampled-line decode matches bytes in order.
//  4 Push tx_valid high for 6 consecutive cycles -> 1 byte in shifter, 4 in FIFO, tx_ready=0 during
//    6th cycle (6th byte not accepted); tx_ready returns 1 one cycle after pop at end of frame 1.
//  5 Reset asserted during data bit 3 of a frame with 2 bytes queued -> midi_tx=1 immediately,
//    busy=0, fifo_count=0; after release, byte 0x55 transmits correctly.
//  6 Push on the same edge as a STOP->START pop with FIFO full-1 -> fifo_count unchanged, order kept.

Source files
------------

// File: rtl/midi_transmitter_pkg.sv
// Shared definitions for the MIDI transmit path.
// Provides clock and baud constants, the byte type and the transmit FSM state type.
package midi_transmitter_pkg;

  localparam int SYSTEM_CLOCK   = 50_000_000;
  localparam int MIDI_BAUD_RATE = 31_250;
  localparam int BYTE_WIDTH     = 8;

  typedef logic [BYTE_WIDTH-1:0] byte_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

endpackage : midi_transmitter_pkg

// File: rtl/midi_transmitter_if.sv
// Byte handshake bus into the MIDI transmitter.
//   tx_data  : byte to send
//   tx_valid : tx_data valid this cycle
//   tx_ready : transmitter can accept; a transfer happens when tx_valid && tx_ready
// master = byte producer, slave = transmitter.
interface midi_transmitter_if;
  import midi_transmitter_pkg::*;

  byte_t tx_data;
  logic  tx_valid;
  logic  tx_ready;

  modport master (output tx_data, output tx_valid, input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, output tx_ready);

endinterface : midi_transmitter_if

// File: rtl/midi_transmitter_byte_fifo.sv
// byte_fifo: small first-word-fall-through FIFO of bytes.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset (empties the FIFO)
//   push_i  : write din_i (ignored when full)
//   din_i   : byte to write
//   pop_i   : drop the head entry (ignored when empty)
//   dout_o  : current head entry, valid while empty_o is low
//   count_o : number of stored entries
//   full_o  : count_o == DEPTH
//   empty_o : count_o == 0
module byte_fifo
  import midi_transmitter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  byte_t                  din_i,
  input  logic                   pop_i,
  output byte_t                  dout_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  byte_t             mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage has no reset: stale entries are never visible because count gates reads.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Power-of-two depth lets the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

endmodule : byte_fifo

// File: rtl/midi_transmitter.sv
// MIDI (UART 8N1) serial transmitter.
// Bytes arrive over the handshake interface into a small FIFO and are shifted out
// LSB first with one start bit and one stop bit, back to back while data is queued.
//   clock      : system clock, rising edge
//   reset_l    : asynchronous active-low reset
//   tx_if      : slave side of the byte handshake (tx_data / tx_valid / tx_ready)
//   midi_tx    : serial line, idle high, driven from a flop
//   busy       : frame in progress or FIFO non-empty
//   fifo_count : bytes waiting in the FIFO (excludes the byte being shifted)
module midi_transmitter
  import midi_transmitter_pkg::*;
#(
  parameter int CLOCK_FREQ = SYSTEM_CLOCK,
  parameter int BAUD_RATE  = MIDI_BAUD_RATE,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset_l,
  midi_transmitter_if.slave           tx_if,
  output logic                        midi_tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int BIT_PERIOD = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W      = (BIT_PERIOD < 2) ? 1 : $clog2(BIT_PERIOD);

  if (BIT_PERIOD < 2) begin : g_bad_bit_period
    $error("midi_transmitter: BIT_PERIOD must be at least 2");
  end

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  byte_t            shift_q, shift_d;
  logic             tx_q, tx_d;

  logic             fifo_pop;
  logic             fifo_full, fifo_empty;
  byte_t            fifo_head;
  logic             bit_end;
  logic [2:0]       bit_idx_inc;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (reset_l),
    .push_i  (tx_if.tx_valid && tx_if.tx_ready),
    .din_i   (tx_if.tx_data),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Ready comes only from the registered count, so it never combinationally depends on valid.
  assign tx_if.tx_ready = !fifo_full;
  assign midi_tx        = tx_q;
  assign busy           = (state_q != ST_IDLE) || !fifo_empty;

  assign bit_end     = (bit_cnt_q == CNT_W'(BIT_PERIOD - 1));
  assign bit_idx_inc = bit_idx_q + 3'd1;

  // The line value is computed for the state being entered, so midi_tx changes
  // on the same edge as the state and stays a clean flop output.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    fifo_pop  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d      = 1'b1;
        bit_cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_head;
          state_d  = ST_START;
          tx_d     = 1'b0;
        end
      end

      ST_START: begin
        bit_cnt_d = bit_end ? '0 : bit_cnt_q + CNT_W'(1);
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end
      end

      ST_DATA: begin
        bit_cnt_d = bit_end ? '0 : bit_cnt_q + CNT_W'(1);
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_inc;
            tx_d      = shift_q[bit_idx_inc];
          end
        end
      end

      ST_STOP: begin
        bit_cnt_d = bit_end ? '0 : bit_cnt_q + CNT_W'(1);
        if (bit_end) begin
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_head;
            state_d  = ST_START;
            tx_d     = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = '0;
        tx_d      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

endmodule : midi_transmitter

// File: tb/tb_midi_transmitter.sv
// Testbench for midi_transmitter, run with a short bit period so whole frames fit the run.
// A reference model tracks the queue of accepted bytes and the position inside the
// current frame; the expected line level is derived from the frame layout arithmetic.
module tb_midi_transmitter;
  import midi_transmitter_pkg::*;

  localparam int BAUD  = 31_250;
  localparam int BP    = 16;
  localparam int CLKF  = BAUD * BP;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * BP;

  logic                   clk = 1'b0;
  logic                   reset_l = 1'b1;
  logic                   midi_tx;
  logic                   busy;
  logic [$clog2(DEPTH):0] fifo_count;

  midi_transmitter_if ifc ();

  midi_transmitter #(
    .CLOCK_FREQ (CLKF),
    .BAUD_RATE  (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock      (clk),
    .reset_l    (reset_l),
    .tx_if      (ifc),
    .midi_tx    (midi_tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;

  // Reference model state.
  byte_t mq[$];
  bit    m_active = 1'b0;
  int    m_pos    = 0;
  byte_t m_cur    = '0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_line();
    int b;
    if (!m_active) return 1'b1;
    b = m_pos / BP;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_cur[b-1];
    return 1'b1;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, "_line"},  midi_tx,    exp_line());
    chk({tag, "_ready"}, ifc.tx_ready, (mq.size() != DEPTH));
    chk({tag, "_busy"},  busy,       (m_active || mq.size() != 0));
    chk({tag, "_count"}, fifo_count, 8'(mq.size()));
  endtask

  // One clock: drive inputs, advance the model at the edge, check #1 after.
  task automatic step(input logic v, input byte_t d, input string tag);
    bit acc, pop;
    ifc.tx_valid = v;
    ifc.tx_data  = d;
    acc = v && (mq.size() != DEPTH);
    pop = (mq.size() != 0) && (!m_active || m_pos == FRAME - 1);
    @(posedge clk);
    if (pop) begin
      m_cur    = mq.pop_front();
      m_active = 1'b1;
      m_pos    = 0;
    end else if (m_active) begin
      m_pos++;
      if (m_pos == FRAME) m_active = 1'b0;
    end
    if (acc) begin
      mq.push_back(d);
      $display("[%0t] %s push 0x%02h queued=%0d", $time, tag, d, mq.size());
    end
    #1;
    check_outputs(tag);
  endtask

  // Asserts reset between edges; line, busy and count must react before any clock.
  task automatic reset_pulse(input int cycles, input string tag);
    ifc.tx_valid = 1'b0;
    #3;
    reset_l = 1'b0;
    #1;
    mq.delete();
    m_active = 1'b0;
    m_pos    = 0;
    $display("[%0t] %s reset asserted", $time, tag);
    check_outputs(tag);
    repeat (cycles) @(posedge clk);
    #2;
    reset_l = 1'b1;
    @(posedge clk);
    #1;
    check_outputs({tag, "_rel"});
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, tag);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < (DEPTH + 2) * FRAME && (m_active || mq.size() != 0); i++)
      step(1'b0, 8'h00, tag);
    chk({tag, "_drained_busy"}, busy, 1'b0);
  endtask

  initial begin
    ifc.tx_valid = 1'b0;
    ifc.tx_data  = '0;

    // 1: reset state
    reset_pulse(5, "t1_reset");

    // 2: single byte with exact frame timing
    step(1'b1, 8'h90, "t2");
    idle(FRAME + 4, "t2");

    // 3: three back-to-back frames
    step(1'b1, 8'h90, "t3");
    step(1'b1, 8'h3C, "t3");
    step(1'b1, 8'h7F, "t3");
    drain("t3");

    // 4: valid held for six cycles, FIFO fills and the last byte is refused
    for (int i = 0; i < 6; i++) step(1'b1, byte_t'($urandom_range(0, 255)), "t4");
    chk("t4_full_ready", ifc.tx_ready, 1'b0);
    drain("t4");

    // 5: reset during data bit 3 with two bytes queued, then a clean frame
    step(1'b1, byte_t'($urandom_range(0, 255)), "t5");
    step(1'b1, byte_t'($urandom_range(0, 255)), "t5");
    step(1'b1, byte_t'($urandom_range(0, 255)), "t5");
    begin
      int n = 0;
      while (!(m_active && m_pos == 4 * BP + 3) && n < 2 * FRAME) begin
        step(1'b0, 8'h00, "t5_wait");
        n++;
      end
      chk("t5_reached_bit3", 8'(n < 2 * FRAME), 8'd1);
    end
    reset_pulse(3, "t5_reset");
    step(1'b1, 8'h55, "t5_after");
    drain("t5_after");

    // 6: push on the STOP->START pop edge with the FIFO one short of full
    for (int i = 0; i < DEPTH; i++) step(1'b1, byte_t'($urandom_range(0, 255)), "t6");
    chk("t6_pre_count", fifo_count, 8'(DEPTH - 1));
    begin
      int n = 0;
      while (!(m_active && m_pos == FRAME - 1) && n < 2 * FRAME) begin
        step(1'b0, 8'h00, "t6_wait");
        n++;
      end
      chk("t6_reached_stop_end", 8'(n < 2 * FRAME), 8'd1);
    end
    step(1'b1, 8'hA5, "t6_pop_push");
    chk("t6_count_kept", fifo_count, 8'(DEPTH - 1));
    drain("t6");

    // 7: random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 3) == 0), byte_t'($urandom_range(0, 255)), "t7");
    drain("t7");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_midi_transmitter
